// File: rtl/sc_frame_packer_if.sv
// FIFO write-side bundle between sc_frame_packer and the external slow-control FIFO.
// The packer uses the master modport; the FIFO (or a bench model of it) uses slave.
interface sc_frame_packer_if #(
  parameter int WORD_W = 8
);
  logic              In_Ex_Fifo_Full;
  logic              Out_Ex_Fifo_Wr_En;
  logic [WORD_W-1:0] Out_Ex_Fifo_Din;

  modport master (
    input  In_Ex_Fifo_Full,
    output Out_Ex_Fifo_Wr_En,
    output Out_Ex_Fifo_Din
  );

  modport slave (
    output In_Ex_Fifo_Full,
    input  Out_Ex_Fifo_Wr_En,
    input  Out_Ex_Fifo_Din
  );
endinterface

// File: rtl/sc_frame_packer.sv
// sc_frame_packer: slow-control serialiser for daisy-chained front-end ASICs.
// On a Start_In rising edge it snapshots up to N_CHIP configuration vectors and
// writes them to the external FIFO as WORD_W-bit words, highest chip first,
// MSB word first, last word zero-padded in its LSBs. Wr_En is combinational on
// In_Ex_Fifo_Full so no write is ever issued while the FIFO reports full.
// Optional feature macro: SC_CRC_EN appends a CRC-8 (poly 0x07) trailer word.
module sc_frame_packer #(
  parameter int PARAM_W = 616,
  parameter int WORD_W  = 8,
  parameter int N_CHIP  = 4
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Start_In,
  input  logic [$clog2(N_CHIP+1)-1:0]    In_Chip_Num,
  input  logic [N_CHIP*PARAM_W-1:0]      In_Param,
  sc_frame_packer_if.master              Ex_Fifo,
  output logic                           Out_Busy,
  output logic                           End_Flag,
  output logic                           Out_Err
);

  localparam int NW    = (PARAM_W + WORD_W - 1) / WORD_W;
  localparam int CHW   = $clog2(N_CHIP + 1);
  localparam int PAD_W = NW * WORD_W;
  localparam int WPW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int DEPTH = N_CHIP * NW;
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef SC_CRC_EN
  if (WORD_W != 8) begin : g_crc_word_w_check
    $error("sc_frame_packer: SC_CRC_EN requires WORD_W == 8");
  end
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
`ifdef SC_CRC_EN
    , CRC
`endif
  } state_t;

  state_t            state;
  logic              start_q;
  logic [CHW-1:0]    chip_ptr;
  logic [WPW-1:0]    word_ptr;
  logic [WORD_W-1:0] din_hold;
  logic [WORD_W-1:0] din_mux;
  logic              wr_en;
  logic              start_rise;
  logic [CHW-1:0]    cnt_clamp;
  logic [IDXW-1:0]   rd_idx;
  logic [PAD_W-1:0]  padded [N_CHIP];
  logic [WORD_W-1:0] mem [DEPTH];
`ifdef SC_CRC_EN
  logic [7:0]        crc_q;

  // MSB-first CRC-8, poly 0x07, init 0, no reflection, no final XOR
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign start_rise = Start_In && !start_q;
  assign cnt_clamp  = (In_Chip_Num > CHW'(N_CHIP)) ? CHW'(N_CHIP) : In_Chip_Num;
  assign rd_idx     = IDXW'(int'(chip_ptr) * NW + int'(word_ptr));

  // Left-align each chip vector in a whole number of words, zero fill below
  always_comb begin
    for (int k = 0; k < N_CHIP; k++) begin
      padded[k] = '0;
      padded[k][PAD_W-1 -: PARAM_W] = In_Param[k*PARAM_W +: PARAM_W];
    end
  end

  // Snapshot: capture every chip's words in LOAD so later In_Param changes are ignored
  always_ff @(posedge Clk) begin
    if (state == LOAD) begin
      for (int k = 0; k < N_CHIP; k++) begin
        for (int w = 0; w < NW; w++) begin
          mem[k*NW + w] <= padded[k][PAD_W-1 - w*WORD_W -: WORD_W];
        end
      end
    end
  end

  // Write data: current word while sending, trailer in CRC, otherwise last written word
  always_comb begin
    din_mux = din_hold;
    wr_en   = 1'b0;
    if (state == SEND) begin
      din_mux = mem[rd_idx];
      wr_en   = !Ex_Fifo.In_Ex_Fifo_Full;
    end
`ifdef SC_CRC_EN
    if (state == CRC) begin
      din_mux = crc_q;
      wr_en   = !Ex_Fifo.In_Ex_Fifo_Full;
    end
`endif
  end

  assign Ex_Fifo.Out_Ex_Fifo_Wr_En = wr_en;
  assign Ex_Fifo.Out_Ex_Fifo_Din   = din_mux;

  // Frame FSM: pointers, start edge detect and registered status outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      chip_ptr <= '0;
      word_ptr <= '0;
      din_hold <= '0;
      Out_Busy <= 1'b0;
      End_Flag <= 1'b0;
      Out_Err  <= 1'b0;
`ifdef SC_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      start_q  <= Start_In;
      End_Flag <= 1'b0;
      Out_Err  <= 1'b0;
      if (wr_en) din_hold <= din_mux;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state    <= LOAD;
            Out_Busy <= 1'b1;
          end
        end
        LOAD: begin
`ifdef SC_CRC_EN
          crc_q <= '0;
`endif
          word_ptr <= '0;
          if (cnt_clamp == '0) begin
            Out_Err  <= 1'b1;
            End_Flag <= 1'b1;
            state    <= DONE;
          end else begin
            Out_Err  <= (In_Chip_Num > CHW'(N_CHIP));
            chip_ptr <= cnt_clamp - CHW'(1);
            state    <= SEND;
          end
        end
        SEND: begin
          if (!Ex_Fifo.In_Ex_Fifo_Full) begin
`ifdef SC_CRC_EN
            crc_q <= crc8_step(crc_q, din_mux);
`endif
            if (word_ptr == WPW'(NW - 1)) begin
              word_ptr <= '0;
              if (chip_ptr == '0) begin
`ifdef SC_CRC_EN
                state <= CRC;
`else
                state    <= DONE;
                End_Flag <= 1'b1;
`endif
              end else begin
                chip_ptr <= chip_ptr - CHW'(1);
              end
            end else begin
              word_ptr <= word_ptr + WPW'(1);
            end
          end
        end
`ifdef SC_CRC_EN
        CRC: begin
          if (!Ex_Fifo.In_Ex_Fifo_Full) begin
            state    <= DONE;
            End_Flag <= 1'b1;
          end
        end
`endif
        DONE: begin
          state    <= IDLE;
          Out_Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (start_rise && state != IDLE) Out_Err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sc_frame_packer.sv
// Bench for sc_frame_packer: a 616-bit/4-chip instance driven through directed
// frames with random vectors and FIFO back-pressure, plus a 12-bit/2-chip
// instance for the zero-padding case. Expected words come from a bit-level model.
module tb_sc_frame_packer;

  localparam int PW  = 616;
  localparam int NCH = 4;
  localparam int NWB = 77;
  localparam int PPW = 12;
  localparam int PNC = 2;
  localparam int PNW = 2;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              Start_In = 1'b0;
  logic [2:0]        Chip_Num = '0;
  logic [NCH*PW-1:0] prm = '0;
  logic              Busy, End_Flag, Err;

  logic              p_start = 1'b0;
  logic [1:0]        p_num = '0;
  logic [PNC*PPW-1:0] p_param = '0;
  logic              p_busy, p_end, p_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] wq[$];
  logic [7:0] pq[$];
  logic [7:0] eq[$];
  int first_cyc, last_cyc, end_cyc, ends, errs, viol, p_ends;

  sc_frame_packer_if #(.WORD_W(8)) b_if ();
  sc_frame_packer_if #(.WORD_W(8)) p_if ();

  sc_frame_packer #(.PARAM_W(PW), .WORD_W(8), .N_CHIP(NCH)) u_big (
    .Clk(Clk), .Rst(Rst), .Start_In(Start_In), .In_Chip_Num(Chip_Num), .In_Param(prm),
    .Ex_Fifo(b_if.master), .Out_Busy(Busy), .End_Flag(End_Flag), .Out_Err(Err)
  );

  sc_frame_packer #(.PARAM_W(PPW), .WORD_W(8), .N_CHIP(PNC)) u_pad (
    .Clk(Clk), .Rst(Rst), .Start_In(p_start), .In_Chip_Num(p_num), .In_Param(p_param),
    .Ex_Fifo(p_if.master), .Out_Busy(p_busy), .End_Flag(p_end), .Out_Err(p_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc = cyc + 1;

  // Capture FIFO traffic mid-cycle, away from the active edge
  always @(negedge Clk) begin
    if (b_if.Out_Ex_Fifo_Wr_En) begin
      if (wq.size() == 0) first_cyc = cyc;
      wq.push_back(b_if.Out_Ex_Fifo_Din);
      last_cyc = cyc;
      if (b_if.In_Ex_Fifo_Full) viol++;
    end
    if (End_Flag) begin
      ends++;
      end_cyc = cyc;
    end
    if (Err) errs++;
    if (p_if.Out_Ex_Fifo_Wr_En) pq.push_back(p_if.Out_Ex_Fifo_Din);
    if (p_end) p_ends++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word w of chip c: bits counted from the vector MSB, zero beyond the LSB
  function automatic logic [7:0] model_word(input logic [NCH*PW-1:0] v, input int pw,
                                            input int c, input int w);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      int i;
      i = pw - 1 - (w * 8 + b);
      r[7-b] = (i >= 0) ? v[c*pw + i] : 1'b0;
    end
    return r;
  endfunction

  task automatic build_exp(input int cnt, input int pw, input int nw, input int nch,
                           input logic [NCH*PW-1:0] v);
    int cl;
    cl = (cnt > nch) ? nch : cnt;
    eq.delete();
    for (int c = cl - 1; c >= 0; c--)
      for (int w = 0; w < nw; w++) eq.push_back(model_word(v, pw, c, w));
`ifdef SC_CRC_EN
    if (cl > 0) begin
      logic [7:0] crc;
      logic fb;
      crc = 8'h00;
      foreach (eq[i])
        for (int b = 7; b >= 0; b--) begin
          fb = crc[7] ^ eq[i][b];
          crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
      eq.push_back(crc);
    end
`endif
  endtask

  task automatic rand_prm();
    for (int j = 0; j < NCH*PW; j += 32) prm[j +: 32] = $urandom;
  endtask

  // mode 0 clean, 1 random Full + vector change, 2 Full 5 cycles after 10th write,
  // 3 reset after 20th write, 4 second start edge while busy
  task automatic frame(input int cnt, input int mode, input int exp_err, input string tag);
    int s, mism, nhold, st, nexp;
    bit rdone;
    rdone = 0;
    st = 0;
    build_exp(cnt, PW, NWB, NCH, prm);
    nexp = eq.size();
    wq.delete();
    ends = 0; errs = 0; viol = 0;
    first_cyc = -1; last_cyc = -1; end_cyc = -1;
    @(posedge Clk); #1;
    Chip_Num = cnt[2:0];
    Start_In = 1'b1;
    s = cyc;
    for (int i = 0; i < 3000 && ends == 0 && !rdone; i++) begin
      @(posedge Clk); #1;
      if (i == 0) check({tag, "_busy_load"}, Busy, 1);
      case (mode)
        1: begin
          b_if.In_Ex_Fifo_Full = ($urandom_range(0, 3) == 0);
          if (i == 5) rand_prm();
        end
        2: begin
          if (wq.size() == 10 && st < 5) begin
            b_if.In_Ex_Fifo_Full = 1'b1;
            st++;
          end else b_if.In_Ex_Fifo_Full = 1'b0;
        end
        3: if (wq.size() == 20) begin
          Rst = 1'b1;
          Start_In = 1'b0;
          @(posedge Clk); #1;
          Rst = 1'b0;
          check({tag, "_wr_after_rst"}, b_if.Out_Ex_Fifo_Wr_En, 0);
          check({tag, "_busy_after_rst"}, Busy, 0);
          repeat (3) @(posedge Clk);
          #1;
          rdone = 1;
        end
        4: begin
          if (i == 30) Start_In = 1'b0;
          if (i == 31) Start_In = 1'b1;
        end
        default: ;
      endcase
    end
    b_if.In_Ex_Fifo_Full = 1'b0;
    nhold = wq.size();
    repeat (6) @(posedge Clk);
    #1;
    check({tag, "_no_retrigger"}, wq.size(), nhold);
    check({tag, "_busy_idle"}, Busy, 0);
    Start_In = 1'b0;
    // The write already under way when Rst is raised still completes: 20 + 1
    if (mode == 3) nexp = 21;
    check({tag, "_count"}, wq.size(), nexp);
    mism = 0;
    for (int i = 0; i < wq.size() && i < eq.size(); i++) if (wq[i] !== eq[i]) mism++;
    check({tag, "_data_mism"}, mism, 0);
    check({tag, "_end_pulses"}, ends, (mode == 3) ? 0 : 1);
    check({tag, "_err_pulses"}, errs, exp_err);
    check({tag, "_wr_while_full"}, viol, 0);
    if ((mode == 0 || mode == 4) && nexp > 0) begin
      check({tag, "_first_wr_cyc"}, first_cyc, s + 2);
      check({tag, "_end_cyc"}, end_cyc, last_cyc + 1);
    end
    if (cnt == 0) check({tag, "_end_cyc"}, end_cyc, s + 2);
  endtask

  initial begin
    b_if.In_Ex_Fifo_Full = 1'b0;
    p_if.In_Ex_Fifo_Full = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_wr_en", b_if.Out_Ex_Fifo_Wr_En, 0);
    check("rst_din", b_if.Out_Ex_Fifo_Din, 0);
    check("rst_busy", Busy, 0);
    check("rst_end", End_Flag, 0);
    check("rst_err", Err, 0);
    Rst = 1'b0;
    repeat (2) @(posedge Clk);

    // Chip k vector filled with byte k+1, three chips requested
    for (int k = 0; k < NCH; k++)
      for (int j = 0; j < PW; j += 8) prm[k*PW + j +: 8] = 8'(k + 1);
    frame(3, 0, 0, "three_chips");
    check("three_chips_first", wq[0], 8'h03);
    check("three_chips_mid", wq[77], 8'h02);
    check("three_chips_last", wq[230], 8'h01);

    for (int j = 0; j < PW; j += 8) prm[j +: 8] = 8'hA5;
    frame(1, 0, 0, "a5_single");
    check("a5_word0", wq[0], 8'hA5);

    rand_prm();
    frame(1, 2, 0, "full10");
    check("full10_word11", wq[10], eq[10]);

    rand_prm();
    frame(4, 1, 0, "rand_full");

    frame(0, 0, 1, "zero_chips");

    rand_prm();
    frame(7, 0, 1, "clamp7");

    rand_prm();
    frame(2, 3, 0, "rst_mid");
    frame(2, 0, 0, "after_rst");

    rand_prm();
    frame(3, 4, 1, "busy_start");

    // 12-bit vectors: second word carries 4 data bits and 4 zero pad bits
    p_param = {12'h123, 12'hABC};
    for (int r = 0; r < 2; r++) begin
      build_exp(r + 1, PPW, PNW, PNC, {{(NCH*PW - PNC*PPW){1'b0}}, p_param});
      pq.delete();
      p_ends = 0;
      @(posedge Clk); #1;
      p_num = 2'(r + 1);
      p_start = 1'b1;
      for (int i = 0; i < 100 && p_ends == 0; i++) @(posedge Clk);
      #1;
      p_start = 1'b0;
      check("pad_end", p_ends, 1);
      check("pad_count", pq.size(), eq.size());
      for (int i = 0; i < pq.size() && i < eq.size(); i++) check("pad_word", pq[i], eq[i]);
      if (r == 0) begin
        check("pad_abc_hi", pq[0], 8'hAB);
        check("pad_abc_lo", pq[1], 8'hC0);
      end
      p_param = 24'($urandom);
      repeat (2) @(posedge Clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
